// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the sync_ram port arbiter: memory map constants and arbiter state encoding.
package ram_port_arbiter_pkg;

    localparam int ADDRESS_SIZE = 16;
    localparam int DATA_WIDTH   = 32;

    // Memory map as seen by the three requesters
    localparam int STATUS_ADDR  = 0;
    localparam int CONFIG_ADDR  = 1;
    localparam int A_OFFSET     = 2;
    localparam int B_OFFSET     = 10002;
    localparam int C_OFFSET     = 20002;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set request at or after 'start', wrapping.
module ram_port_arbiter_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(start) + i) % N;
            if (!any && req[k]) begin
                gnt[k] = 1'b1;
                idx    = IW'(k);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port sync_ram between NUM_REQ requesters with rotating priority,
// bounded bursts, a registered memory command and read data steered back by a tag pipe.
module ram_port_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDRESS_SIZE = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              we,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [ADDRESS_SIZE-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_Din,
    output logic                            mem_read,
    output logic                            mem_writeEn,
    input  logic [DATA_WIDTH-1:0]           mem_Dout
);

    import ram_port_arbiter_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t          state, state_n;
    logic [IW-1:0]       owner, owner_n, ptr, ptr_n, owner_inc, pick_start, pick_idx, win;
    logic [CW-1:0]       count, count_n;
    logic [NUM_REQ-1:0]  own_mask, others, pick_req, pick_gnt, gnt_c;
    logic                pick_any, accept;
    logic                tag_valid;
    logic [IW-1:0]       tag_idx;

    assign own_mask   = NUM_REQ'(1) << owner;
    assign others     = req & ~own_mask;
    assign owner_inc  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign pick_start = (state == S_OWNED) ? owner_inc : ptr;
    assign pick_req   = (state == S_OWNED) ? others : req;

    ram_port_arbiter_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (pick_req),
        .start (pick_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            owner <= '0;
            ptr   <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            count <= count_n;
        end
    end

    // The owner keeps the port until its burst budget runs out while someone else waits;
    // when it lets go, the hand-over happens in the same cycle so the memory never idles.
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        count_n = count;
        gnt_c   = '0;
        win     = owner;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    gnt_c   = pick_gnt;
                    win     = pick_idx;
                    accept  = 1'b1;
                    state_n = S_OWNED;
                    owner_n = pick_idx;
                    count_n = CW'(1);
                end
            end
            S_OWNED: begin
                if (req[owner] && ((count < CW'(MAX_BURST)) || !(|others))) begin
                    gnt_c  = own_mask;
                    win    = owner;
                    accept = 1'b1;
                    if (count < CW'(MAX_BURST))
                        count_n = count + 1'b1;
                end else if (pick_any) begin
                    gnt_c   = pick_gnt;
                    win     = pick_idx;
                    accept  = 1'b1;
                    owner_n = pick_idx;
                    count_n = CW'(1);
                    ptr_n   = owner_inc;
                end else begin
                    state_n = S_IDLE;
                    ptr_n   = owner_inc;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign gnt = reset ? '0 : gnt_c;

    // Command register; the tag and rvalid stages follow a read through the RAM's one-cycle latency
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_Din     <= '0;
            mem_read    <= 1'b0;
            mem_writeEn <= 1'b0;
            tag_valid   <= 1'b0;
            tag_idx     <= '0;
            rvalid      <= '0;
        end else begin
            if (accept) begin
                mem_addr    <= addr[int'(win)*ADDRESS_SIZE +: ADDRESS_SIZE];
                mem_Din     <= wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                mem_read    <= ~we[win];
                mem_writeEn <= we[win];
            end else begin
                mem_addr    <= '0;
                mem_read    <= 1'b0;
                mem_writeEn <= 1'b0;
            end
            tag_valid <= accept & ~we[win];
            tag_idx   <= win;
            rvalid    <= tag_valid ? (NUM_REQ'(1) << tag_idx) : '0;
        end
    end

    assign rdata = mem_Dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: table of per-cycle vectors for grant/command, scoreboard for read returns.
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req, we;
    logic [47:0] addr;
    logic [95:0] wdata;
    logic [2:0]  gnt, rvalid;
    logic [31:0] rdata, mem_Din, mem_Dout;
    logic [15:0] mem_addr;
    logic        mem_read, mem_writeEn;

    logic [2:0]  gnt_rr, rvalid_rr;
    logic [31:0] rdata_rr, mem_Din_rr;
    logic [15:0] mem_addr_rr;
    logic        mem_read_rr, mem_writeEn_rr;
    logic [31:0] mem_Dout_rr;

    ram_port_arbiter #(.NUM_REQ(3), .ADDRESS_SIZE(16), .DATA_WIDTH(32), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_Din(mem_Din),
        .mem_read(mem_read), .mem_writeEn(mem_writeEn), .mem_Dout(mem_Dout)
    );

    ram_port_arbiter #(.NUM_REQ(3), .ADDRESS_SIZE(16), .DATA_WIDTH(32), .MAX_BURST(1)) dut_rr (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_rr), .rvalid(rvalid_rr), .rdata(rdata_rr), .mem_addr(mem_addr_rr), .mem_Din(mem_Din_rr),
        .mem_read(mem_read_rr), .mem_writeEn(mem_writeEn_rr), .mem_Dout(mem_Dout_rr)
    );

    typedef struct {
        logic             rst;
        logic [2:0]       req;
        logic [2:0]       we;
        logic [2:0][15:0] a;
        logic [2:0][31:0] d;
        logic [2:0]       gnt;
        logic [2:0]       rr;
        logic             chk_rr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb[$];
    vec_t        prev;
    bit          have_prev;
    bit          mon_en;
    int          cyc;
    int          n_checks;
    int          n_errors;
    logic [31:0] ram     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic [2:0]  exp_rv;
    logic [15:0] mon_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sync_ram behind the arbiter under test
    always @(posedge clk) begin
        if (mem_writeEn) ram[mem_addr] <= mem_Din;
        if (mem_read)    mem_Dout <= ram[mem_addr];
    end

    assign mem_Dout_rr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] r, input logic [2:0] w,
                                input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                                input logic [31:0] dv, input logic [2:0] g, input logic [2:0] rr,
                                input logic crr);
        vec_t v;
        v.rst    = rst;
        v.req    = r;
        v.we     = w;
        v.a      = {a2, a1, a0};
        v.d      = {dv + 32'd2, dv + 32'd1, dv};
        v.gnt    = g;
        v.rr     = rr;
        v.chk_rr = crr;
        return v;
    endfunction

    function automatic vec_t idle_vec(input logic rst);
        return mk(rst, 3'b000, 3'b000, 16'd0, 16'd0, 16'd0, 32'd0, 3'b000, 3'b000, 1'b0);
    endfunction

    // Every accepted read is expected back on its requester exactly two cycles after the grant
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) sb.delete();
            exp_rv = '0;
            if (sb.size() > 0 && sb[0].due == cyc) exp_rv = 3'b001 << sb[0].idx;
            check("rvalid", 32'(rvalid), 32'(exp_rv));
            if (exp_rv != 3'b000) begin
                check("rdata", rdata, sb[0].data);
                void'(sb.pop_front());
            end
            if (!reset) begin
                for (int k = 0; k < 3; k++) begin
                    if (req[k] && gnt[k]) begin
                        mon_a = addr[k*16 +: 16];
                        if (we[k]) ref_mem[mon_a] = wdata[k*32 +: 32];
                        else       sb.push_back('{idx: k, data: ref_mem[mon_a], due: cyc + 2});
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        reset = v.rst;
        req   = v.req;
        we    = v.we;
        addr  = v.a;
        wdata = v.d;
        @(negedge clk);
    endtask

    task automatic checkOutput(input vec_t v);
        logic        e_rd, e_we, has;
        logic [15:0] e_addr;
        logic [31:0] e_din;
        check("gnt", 32'(gnt), 32'(v.gnt));
        if (v.chk_rr) check("gnt_rr", 32'(gnt_rr), 32'(v.rr));
        if (have_prev) begin
            e_rd = 1'b0; e_we = 1'b0; has = 1'b0; e_addr = '0; e_din = '0;
            if (!prev.rst) begin
                for (int k = 0; k < 3; k++) begin
                    if (prev.gnt[k]) begin
                        e_rd   = ~prev.we[k];
                        e_we   = prev.we[k];
                        e_addr = prev.a[k];
                        e_din  = prev.d[k];
                        has    = 1'b1;
                    end
                end
            end
            check("mem_read", 32'(mem_read), 32'(e_rd));
            check("mem_writeEn", 32'(mem_writeEn), 32'(e_we));
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (has) check("mem_Din", mem_Din, e_din);
        end
        prev      = v;
        have_prev = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic [2:0] r, g;
        n_checks = 0; n_errors = 0; cyc = 0; have_prev = 1'b0; mon_en = 1'b0;
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 32'hC0DE0000 ^ i;
            ref_mem[i] = 32'hC0DE0000 ^ i;
        end
        ram[2] = 32'hA; ram[3] = 32'hB; ram[4] = 32'hC;
        ref_mem[2] = 32'hA; ref_mem[3] = 32'hB; ref_mem[4] = 32'hC;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Requester 0 alone, three reads
        vecs.push_back(idle_vec(1'b1));
        for (int s = 0; s < 3; s++)
            vecs.push_back(mk(1'b0, 3'b001, 3'b000, 16'(2 + s), 16'd0, 16'd0, 32'd0, 3'b001, 3'b000, 1'b0));
        vecs.push_back(idle_vec(1'b0));
        vecs.push_back(idle_vec(1'b0));

        // All three held: burst-of-8 instance keeps 0, burst-of-1 instance rotates 0,1,2
        vecs.push_back(mk(1'b1, 3'b000, 3'b000, 16'd0, 16'd0, 16'd0, 32'd0, 3'b000, 3'b000, 1'b1));
        for (int s = 0; s < 6; s++)
            vecs.push_back(mk(1'b0, 3'b111, 3'b000, 16'(10 + s), 16'(20 + s), 16'(30 + s), 32'd0,
                              3'b001, 3'b001 << (s % 3), 1'b1));
        vecs.push_back(mk(1'b0, 3'b000, 3'b000, 16'd0, 16'd0, 16'd0, 32'd0, 3'b000, 3'b000, 1'b1));
        vecs.push_back(idle_vec(1'b0));

        // Burst limit: req1 waits from beat 3 and gets beat 9
        vecs.push_back(idle_vec(1'b1));
        for (int s = 1; s <= 21; s++) begin
            r = (s >= 3 && s <= 9) ? 3'b011 : 3'b001;
            g = (s == 9) ? 3'b010 : 3'b001;
            vecs.push_back(mk(1'b0, r, 3'b000, 16'(200 + s), 16'(300 + s), 16'd0, 32'd0, g, 3'b000, 1'b0));
        end
        vecs.push_back(idle_vec(1'b0));
        vecs.push_back(idle_vec(1'b0));

        // Requester 1 writes 0x12345678 (dv+1), requester 2 reads it back next cycle
        vecs.push_back(idle_vec(1'b1));
        vecs.push_back(mk(1'b0, 3'b010, 3'b010, 16'd0, 16'd20002, 16'd0, 32'h12345677, 3'b010, 3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 3'b100, 3'b000, 16'd0, 16'd0, 16'd20002, 32'd0, 3'b100, 3'b000, 1'b0));
        vecs.push_back(idle_vec(1'b0));
        vecs.push_back(idle_vec(1'b0));

        // Owner 1 drops mid-burst; requester 0 takes over with no bubble
        vecs.push_back(idle_vec(1'b1));
        vecs.push_back(mk(1'b0, 3'b010, 3'b000, 16'd0,   16'd400, 16'd0, 32'd0, 3'b010, 3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 3'b011, 3'b000, 16'd500, 16'd401, 16'd0, 32'd0, 3'b010, 3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 3'b011, 3'b000, 16'd501, 16'd402, 16'd0, 32'd0, 3'b010, 3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 3'b000, 16'd502, 16'd0,   16'd0, 32'd0, 3'b001, 3'b000, 1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 3'b000, 16'd503, 16'd0,   16'd0, 32'd0, 3'b001, 3'b000, 1'b0));
        vecs.push_back(idle_vec(1'b0));
        vecs.push_back(idle_vec(1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Reset the cycle after a read accept: the read must never come back
        v = idle_vec(1'b1);
        applyStimulus(v); checkOutput(v);
        v = mk(1'b0, 3'b100, 3'b000, 16'd0, 16'd0, 16'd50, 32'd0, 3'b100, 3'b000, 1'b0);
        applyStimulus(v); checkOutput(v);
        v = mk(1'b1, 3'b100, 3'b000, 16'd0, 16'd0, 16'd50, 32'd0, 3'b000, 3'b000, 1'b0);
        applyStimulus(v); checkOutput(v);
        v = mk(1'b0, 3'b011, 3'b000, 16'd60, 16'd70, 16'd0, 32'd0, 3'b001, 3'b000, 1'b0);
        applyStimulus(v); checkOutput(v);
        check("rvalid_after_reset", 32'(rvalid), 32'd0);
        check("mem_read_after_reset", 32'(mem_read), 32'd0);
        v = idle_vec(1'b0);
        applyStimulus(v); checkOutput(v);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            v = idle_vec(1'b0);
            applyStimulus(v); checkOutput(v);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL drain: pending reads=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
